// File: rtl/disp_src_select.sv
// Debug-value selector for the hex display: debounced pushbuttons step through pc/inst/alu/mem sources.
// Optional freeze button compiled in with `define DISP_FREEZE_EN.

module disp_src_btn #(
    parameter int DB_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);
    logic [1:0]         sync_q, sync_d;
    logic [DB_BITS-1:0] cnt_q, cnt_d;
    logic               lvl_q, lvl_d;
    logic               hist_q, hist_d;
    logic               pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = '0;
        lvl_d   = lvl_q;
        hist_d  = lvl_q;
        pulse_d = lvl_q & ~hist_q;
        // Counter only runs while the synchronised input disagrees; any bounce restarts it.
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == {DB_BITS{1'b1}}) begin
                lvl_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

module disp_src_select #(
    parameter int DB_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_freeze,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] alu_out,
    input  logic [31:0] mem_rdata,
    output logic [31:0] disp_num,
    output logic [1:0]  mode,
    output logic        frozen
);
    logic        next_pulse;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] disp_q, disp_d;
    logic [31:0] src_sel;
    logic        frozen_cur;

    disp_src_btn #(.DB_BITS(DB_BITS)) u_btn_next (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_next),
        .pulse   (next_pulse)
    );

`ifdef DISP_FREEZE_EN
    logic frz_pulse;
    logic frozen_q, frozen_d;

    disp_src_btn #(.DB_BITS(DB_BITS)) u_btn_freeze (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_freeze),
        .pulse   (frz_pulse)
    );

    always_comb begin
        frozen_d = frozen_q ^ frz_pulse;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frozen_q <= 1'b0;
        end else begin
            frozen_q <= frozen_d;
        end
    end

    assign frozen_cur = frozen_q;
`else
    logic unused_btn_freeze;
    assign unused_btn_freeze = btn_freeze;
    assign frozen_cur        = 1'b0;
`endif

    always_comb begin
        src_sel = pc;
        case (mode_q)
            2'd0:    src_sel = pc;
            2'd1:    src_sel = inst;
            2'd2:    src_sel = alu_out;
            default: src_sel = mem_rdata;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        if (next_pulse) begin
            mode_d = mode_q + 2'd1;
        end
        // Held while frozen so a scanned display never sees a mid-update value.
        disp_d = frozen_cur ? disp_q : src_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'd0;
            disp_q <= '0;
        end else begin
            mode_q <= mode_d;
            disp_q <= disp_d;
        end
    end

    assign disp_num = disp_q;
    assign mode     = mode_q;
    assign frozen   = frozen_cur;
endmodule

// File: tb/tb_disp_src_select.sv
// Directed bench for disp_src_select with DB_BITS=2; mode/disp_num changes are checked against a scoreboard.
module tb_disp_src_select;
    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next;
    logic        btn_freeze;
    logic [31:0] pc, inst, alu_out, mem_rdata;
    logic [31:0] disp_num;
    logic [1:0]  mode;
    logic        frozen;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  exp_mode_q[$];
    logic [31:0] exp_disp_q[$];
    logic [1:0]  prev_mode = 2'd0;
    logic [31:0] prev_disp = 32'd0;

    disp_src_select #(.DB_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_freeze (btn_freeze),
        .pc         (pc),
        .inst       (inst),
        .alu_out    (alu_out),
        .mem_rdata  (mem_rdata),
        .disp_num   (disp_num),
        .mode       (mode),
        .frozen     (frozen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every change of mode/disp_num must match the next queued expectation.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_mode <= mode;
            prev_disp <= disp_num;
        end else begin
            if (mode !== prev_mode) begin
                if (exp_mode_q.size() == 0) chk("mode_unexpected", {30'd0, mode}, {30'd0, prev_mode});
                else chk("mode_sb", {30'd0, mode}, {30'd0, exp_mode_q.pop_front()});
            end
            if (disp_num !== prev_disp) begin
                if (exp_disp_q.size() == 0) chk("disp_unexpected", disp_num, prev_disp);
                else chk("disp_sb", disp_num, exp_disp_q.pop_front());
            end
            prev_mode <= mode;
            prev_disp <= disp_num;
        end
    end

    // Clean press held 10 cycles; mode must move exactly on the 8th edge, disp_num on the 9th.
    task automatic press_next(input logic [1:0] exp_mode, input logic [31:0] exp_disp, input bit disp_moves);
        exp_mode_q.push_back(exp_mode);
        if (disp_moves) exp_disp_q.push_back(exp_disp);
        @(negedge clk) btn_next = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("mode_before_edge8", {30'd0, mode}, {30'd0, exp_mode - 2'd1});
        @(posedge clk);
        #1 chk("mode_edge8", {30'd0, mode}, {30'd0, exp_mode});
        @(posedge clk);
        #1 chk("disp_edge9", disp_num, exp_disp);
        @(negedge clk) btn_next = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("mode_after_release", {30'd0, mode}, {30'd0, exp_mode});
    endtask

`ifdef DISP_FREEZE_EN
    task automatic press_freeze(input logic exp_frz, input logic [31:0] exp_disp, input bit disp_moves);
        if (disp_moves) exp_disp_q.push_back(exp_disp);
        @(negedge clk) btn_freeze = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("frozen_before_edge8", {31'd0, frozen}, {31'd0, ~exp_frz});
        @(posedge clk);
        #1 chk("frozen_edge8", {31'd0, frozen}, {31'd0, exp_frz});
        @(posedge clk);
        #1 chk("disp_after_freeze", disp_num, exp_disp);
        @(negedge clk) btn_freeze = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("frozen_after_release", {31'd0, frozen}, {31'd0, exp_frz});
    endtask
`endif

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_disp", disp_num, 32'd0);
        chk("rst_frozen", {31'd0, frozen}, 32'd0);
        repeat (2) @(negedge clk);
        exp_disp_q.push_back(pc);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("disp_after_rst", disp_num, pc);
    endtask

    initial begin
        rst        = 1'b1;
        btn_next   = 1'b0;
        btn_freeze = 1'b0;
        pc         = 32'h0000_0040;
        inst       = 32'h2002_0005;
        alu_out    = 32'hDEAD_BEEF;
        mem_rdata  = 32'h1234_5678;
        do_reset();

        // Bouncy press never reaches a full stable count.
        @(negedge clk) btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk) btn_next = 1'b1;
        repeat (2) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("glitch_mode", {30'd0, mode}, 32'd0);
        chk("glitch_disp", disp_num, 32'h0000_0040);

        press_next(2'd1, 32'h2002_0005, 1'b1);
        press_next(2'd2, 32'hDEAD_BEEF, 1'b1);

        // Reset mid-run with mode=2 clears everything asynchronously.
        do_reset();

        press_next(2'd1, 32'h2002_0005, 1'b1);
        press_next(2'd2, 32'hDEAD_BEEF, 1'b1);
        press_next(2'd3, 32'h1234_5678, 1'b1);
        press_next(2'd0, 32'h0000_0040, 1'b1);

`ifdef DISP_FREEZE_EN
        press_next(2'd1, 32'h2002_0005, 1'b1);
        press_next(2'd2, 32'hDEAD_BEEF, 1'b1);
        press_freeze(1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk) alu_out = 32'h0;
        repeat (3) @(posedge clk);
        #1 chk("frozen_hold_disp", disp_num, 32'hDEAD_BEEF);
        press_next(2'd3, 32'hDEAD_BEEF, 1'b0);
        press_freeze(1'b0, 32'h1234_5678, 1'b1);
`else
        // Freeze button is inert; disp_num follows pc with one cycle of latency.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) btn_freeze = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1 chk("frozen_tied", {31'd0, frozen}, 32'd0);
            end
            @(negedge clk) btn_freeze = 1'b0;
            pc = 32'h0000_0100 + 32'(k);
            inst = 32'hA5A5_0000 + 32'(k);
            exp_disp_q.push_back(32'h0000_0100 + 32'(k));
            @(posedge clk);
            #1 chk("disp_tracks_pc", disp_num, 32'h0000_0100 + 32'(k));
            repeat (8) @(posedge clk);
            #1 chk("frozen_tied_idle", {31'd0, frozen}, 32'd0);
        end
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("mode_queue_drained", exp_mode_q.size(), 32'd0);
        chk("disp_queue_drained", exp_disp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
